viterbi_acs_sched: RTL and testbench

VITERBI_ACS_SCHED -- requirements
Module: viterbi_acs_sched

---
 rtl/viterbi_acs_sched.sv | 135 +++++++++++++
 tb/tb_viterbi_acs_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs_sched.sv
// rtl/viterbi_acs_sched.sv - Viterbi ACS group scheduler (optional normalization: ACS_SCHED_NORM_EN)
module viterbi_acs_sched #(
  parameter int GRP_W = 2,
  parameter int SYM_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             rx_pair,
  output logic [1:0]             bmc_rx,
  output logic                   acs_en,
  output logic [GRP_W-1:0]       acs_grp,
  output logic                   pm_sel,
  output logic                   sm_we,
  output logic [SYM_W+GRP_W-1:0] sm_waddr,
  input  logic                   norm_req,
  output logic                   acs_norm,
  output logic                   tb_req,
  input  logic                   tb_ack
);

  localparam logic [GRP_W-1:0] GRP_LAST = '1;
  localparam logic [SYM_W-1:0] SYM_LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, TB_WAIT} state_t;

  state_t             state_q, state_d;
  logic [GRP_W-1:0]   grp_q;
  logic [SYM_W-1:0]   sym_cnt_q;
  logic               pm_sel_q;
  logic [1:0]         bmc_rx_q;
  logic               last_grp;
  logic               frame_end;
  logic               accept;

  assign last_grp  = (grp_q == GRP_LAST);
  assign frame_end = last_grp && (sym_cnt_q == SYM_LAST);
  assign accept    = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake/strobe outputs; all strobes are held low while rst is high
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    acs_en   = 1'b0;
    tb_req   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        acs_en   = 1'b1;
        in_ready = last_grp && !frame_end;
        if (last_grp) begin
          if (frame_end)     state_d = TB_WAIT;
          else if (in_valid) state_d = RUN;
          else               state_d = IDLE;
        end
      end
      TB_WAIT: begin
        tb_req = 1'b1;
        if (tb_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      in_ready = 1'b0;
      acs_en   = 1'b0;
      tb_req   = 1'b0;
    end
  end

  // Group/symbol counters, ping-pong select and received-pair latch
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q     <= '0;
      sym_cnt_q <= '0;
      pm_sel_q  <= 1'b0;
      bmc_rx_q  <= 2'b00;
    end else begin
      if (accept) bmc_rx_q <= rx_pair;
      if (state_q == RUN) begin
        grp_q <= grp_q + 1'b1;
        if (last_grp) begin
          pm_sel_q  <= ~pm_sel_q;
          sym_cnt_q <= sym_cnt_q + 1'b1;
        end
      end else begin
        grp_q <= '0;
      end
    end
  end

  assign bmc_rx   = bmc_rx_q;
  assign pm_sel   = pm_sel_q;
  assign sm_we    = acs_en;
  assign acs_grp  = acs_en ? grp_q : '0;
  assign sm_waddr = acs_en ? {sym_cnt_q, grp_q} : '0;

`ifdef ACS_SCHED_NORM_EN
  logic norm_flag_q;
  logic norm_cur_q;
  logic norm_pend;

  // A request seen in RUN (including the closing cycle) is pending for the next symbol
  assign norm_pend = norm_flag_q || (acs_en && norm_req);

  // norm_cur_q applies to the symbol in flight; the flag collects requests for the one after
  always_ff @(posedge clk) begin
    if (rst) begin
      norm_flag_q <= 1'b0;
      norm_cur_q  <= 1'b0;
    end else if (accept) begin
      norm_cur_q  <= norm_pend;
      norm_flag_q <= 1'b0;
    end else if (acs_en) begin
      norm_flag_q <= norm_pend;
    end
  end

  assign acs_norm = acs_en && norm_cur_q;
`else
  logic unused_norm_req;
  assign unused_norm_req = norm_req;
  assign acs_norm        = 1'b0;
`endif

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// tb/tb_viterbi_acs_sched.sv - self-checking bench for viterbi_acs_sched (honours ACS_SCHED_NORM_EN)
module tb_viterbi_acs_sched;
  localparam int GRP_W = 2;
  localparam int SYM_W = 6;
  localparam int NG    = 1 << GRP_W;
  localparam int FL    = 1 << SYM_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             rx_pair;
  logic [1:0]             bmc_rx;
  logic                   acs_en;
  logic [GRP_W-1:0]       acs_grp;
  logic                   pm_sel;
  logic                   sm_we;
  logic [SYM_W+GRP_W-1:0] sm_waddr;
  logic                   norm_req;
  logic                   acs_norm;
  logic                   tb_req;
  logic                   tb_ack;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase 0=idle 1=run 2=wait, k = group within symbol,
  // syms = symbols completed since reset (address and bank select derive from it)
  bit       m_valid = 0;
  int       m_phase = 0;
  int       m_k     = 0;
  int       m_syms  = 0;
  logic [1:0] m_rx  = 2'b00;
  bit       m_flag  = 0;
  bit       m_cur   = 0;

  always #5 clk = ~clk;

  viterbi_acs_sched #(.GRP_W(GRP_W), .SYM_W(SYM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rx_pair(rx_pair), .bmc_rx(bmc_rx), .acs_en(acs_en), .acs_grp(acs_grp),
    .pm_sel(pm_sel), .sm_we(sm_we), .sm_waddr(sm_waddr), .norm_req(norm_req),
    .acs_norm(acs_norm), .tb_req(tb_req), .tb_ack(tb_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic [1:0] rx,
                      input logic ack, input logic nreq);
    bit e_run, e_rdy, e_tb, e_norm, pend, last_sym;
    int e_grp, e_addr;
    rst = r; in_valid = v; rx_pair = rx; tb_ack = ack; norm_req = nreq;
    #1;
    e_run  = !r && m_phase == 1;
    e_rdy  = !r && (m_phase == 0 || (m_phase == 1 && m_k == NG-1 && (m_syms % FL) != FL-1));
    e_tb   = !r && m_phase == 2;
    e_grp  = e_run ? m_k : 0;
    e_addr = e_run ? (m_syms % FL) * NG + m_k : 0;
`ifdef ACS_SCHED_NORM_EN
    e_norm = e_run && m_cur;
`else
    e_norm = 1'b0;
`endif
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("acs_en",   32'(acs_en),   32'(e_run));
    chk("sm_we",    32'(sm_we),    32'(e_run));
    chk("acs_grp",  32'(acs_grp),  32'(e_grp));
    chk("sm_waddr", 32'(sm_waddr), 32'(e_addr));
    chk("tb_req",   32'(tb_req),   32'(e_tb));
    chk("acs_norm", 32'(acs_norm), 32'(e_norm));
    if (m_valid) begin
      chk("pm_sel", 32'(pm_sel), 32'(m_syms % 2));
      chk("bmc_rx", 32'(bmc_rx), 32'(m_rx));
    end
    @(posedge clk);
    if (r) begin
      m_valid = 1; m_phase = 0; m_k = 0; m_syms = 0; m_rx = 2'b00; m_flag = 0; m_cur = 0;
    end else begin
      case (m_phase)
        0: if (v) begin
          m_rx = rx; m_phase = 1; m_k = 0; m_cur = m_flag; m_flag = 0;
        end
        1: begin
          pend = m_flag || nreq;
          if (m_k < NG-1) begin
            m_k++; m_flag = pend;
          end else begin
            last_sym = (m_syms % FL) == FL-1;
            m_syms++; m_k = 0;
            if (last_sym) begin
              m_phase = 2; m_flag = pend;
            end else if (v) begin
              m_rx = rx; m_cur = pend; m_flag = 0;
            end else begin
              m_phase = 0; m_flag = pend;
            end
          end
        end
        default: if (ack) m_phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; rx_pair = 2'b00; tb_ack = 1'b0; norm_req = 1'b0;
    @(negedge clk);

    // Reset, then a single symbol 2'b10
    tick(1, 0, 2'b00, 0, 0);
    tick(1, 0, 2'b00, 0, 0);
    tick(0, 1, 2'b10, 0, 0);
    for (int i = 0; i < NG; i++) tick(0, 0, 2'(i), 0, 0);
    chk("single_pm_sel", 32'(pm_sel), 32'd1);
    chk("single_bmc_rx", 32'(bmc_rx), 32'd2);
    chk("single_idle_rdy", 32'(in_ready), 32'd1);
    tick(0, 0, 2'b00, 1, 1);

    // Three back-to-back symbols with in_valid held
    for (int i = 0; i < 3*NG; i++) tick(0, 1, 2'($urandom), 0, 0);
    tick(0, 0, 2'b00, 0, 0);
    chk("b2b_pm_sel", 32'(pm_sel), 32'd0);

    // Normalization request at grp 1 of symbol 0
    tick(1, 0, 2'b00, 0, 0);
    tick(0, 1, 2'b01, 0, 0);
    tick(0, 1, 2'b01, 0, 0);
    tick(0, 1, 2'b01, 0, 1);
    for (int i = 0; i < 3*NG - 2; i++) tick(0, 1, 2'($urandom), 0, 0);
    tick(0, 0, 2'b00, 0, 0);

    // Full frame, traceback handshake after 5 waiting cycles
    tick(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 1 + FL*NG; i++) tick(0, 1, 2'($urandom), 0, 0);
    chk("frame_tb_req", 32'(tb_req), 32'd1);
    chk("frame_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) tick(0, 1, 2'b11, 0, 0);
    tick(0, 1, 2'b11, 1, 0);
    tick(0, 1, 2'b01, 0, 0);
    tick(0, 0, 2'b00, 0, 0);
    chk("after_tb_waddr", 32'(sm_waddr), 32'd1);

    // Reset at grp 2 of symbol 5
    tick(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 1 + 5*NG + 2; i++) tick(0, 1, 2'($urandom), 0, 0);
    tick(1, 1, 2'b11, 0, 0);
    chk("midrst_acs_en", 32'(acs_en), 32'd0);
    chk("midrst_pm_sel", 32'(pm_sel), 32'd0);
    tick(0, 1, 2'b10, 0, 0);
    for (int i = 0; i < NG; i++) tick(0, 0, 2'b00, 0, 0);

    // Randomized traffic with occasional resets, stray acks and norm requests
    for (int i = 0; i < 1500; i++)
      tick(($urandom_range(99) == 0), ($urandom_range(9) < 7), 2'($urandom),
           ($urandom_range(9) < 3), ($urandom_range(9) < 2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
